// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multiport register file with bypass, zero register and bulk clear
//
// Flop-based register file. It has two combinational read ports and one write port.
// A two-state engine sweeps every entry to zero, one entry per clock, after a Clear request.
//
// Parameters
//   WIDTH     data bits per register
//   DEPTH     number of registers (power of two, >= 2)
//   AW        address width, derived from DEPTH
//   ZERO_REG  1: register 0 always reads 0 and ignores writes
//   BYPASS    1: a same-cycle write to a read address is forwarded to that read port
//
// Ports
//   Clk            rising-edge clock
//   Reset_n        asynchronous active-low reset
//   ReadRegister1  read port 1 address
//   ReadRegister2  read port 2 address
//   ReadData1      read port 1 data (combinational)
//   ReadData2      read port 2 data (combinational)
//   WriteRegister  write address
//   WriteData      write data
//   RegWrite       write enable
//   Clear          bulk-clear request
//   Busy           high while the clear sweep is running

module regfile_multiport #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [AW-1:0]    ReadRegister1,
   input  logic [AW-1:0]    ReadRegister2,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2,
   input  logic [AW-1:0]    WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             RegWrite,
   input  logic             Clear,
   output logic             Busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] regs_q [DEPTH];

   logic             idle;
   logic             wr_zero_hit;
   logic             wr_en;
   logic             clr_en;

   // ------------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      unique case (state_q)
         ST_IDLE: begin
            if (Clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            // Clear requests are ignored here. The sweep always runs to the last index.
            if (cnt_q == LAST_IDX) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign idle   = (state_q == ST_IDLE);
   assign clr_en = (state_q == ST_CLEAR);

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   assign wr_zero_hit = ZERO_REG && (WriteRegister == '0);

   // A Clear sampled in IDLE takes priority over a write on the same edge.
   // Any write arriving during the sweep is discarded.
   assign wr_en = idle && RegWrite && !Clear && !wr_zero_hit;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (clr_en) begin
         regs_q[cnt_q] <= '0;
      end else if (wr_en) begin
         regs_q[WriteRegister] <= WriteData;
      end
   end

   // ------------------------------------------------------------------
   // Read ports
   // Priority: zero register, then bypass, then array contents.
   // Bypass is only live in IDLE, so reads during the sweep see the array.
   // ------------------------------------------------------------------
   always_comb begin
      ReadData1 = regs_q[ReadRegister1];
      if (ZERO_REG && (ReadRegister1 == '0)) begin
         ReadData1 = '0;
      end else if (BYPASS && idle && RegWrite && (WriteRegister == ReadRegister1)) begin
         ReadData1 = WriteData;
      end
   end

   always_comb begin
      ReadData2 = regs_q[ReadRegister2];
      if (ZERO_REG && (ReadRegister2 == '0)) begin
         ReadData2 = '0;
      end else if (BYPASS && idle && RegWrite && (WriteRegister == ReadRegister2)) begin
         ReadData2 = WriteData;
      end
   end

   assign Busy = busy_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - randomized self-checking bench for regfile_multiport
module tb_regfile_multiport;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] wd;
   logic        we, clr;
   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        busy_a, busy_b;

   logic [2:0]  ra1_c, ra2_c, wa_c;
   logic [7:0]  wd_c;
   logic        we_c, clr_c;
   logic [7:0]  rd1_c, rd2_c;
   logic        busy_c;

   int checks   = 0;
   int failures = 0;

   // a: defaults (zero reg + bypass); b: same stimulus, neither feature; c: 8x8
   regfile_multiport dut_a (
      .Clk(clk), .Reset_n(rst_n),
      .ReadRegister1(ra1), .ReadRegister2(ra2),
      .ReadData1(rd1_a), .ReadData2(rd2_a),
      .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
      .Clear(clr), .Busy(busy_a)
   );

   regfile_multiport #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .Clk(clk), .Reset_n(rst_n),
      .ReadRegister1(ra1), .ReadRegister2(ra2),
      .ReadData1(rd1_b), .ReadData2(rd2_b),
      .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
      .Clear(clr), .Busy(busy_b)
   );

   regfile_multiport #(.WIDTH(8), .DEPTH(8)) dut_c (
      .Clk(clk), .Reset_n(rst_n),
      .ReadRegister1(ra1_c), .ReadRegister2(ra2_c),
      .ReadData1(rd1_c), .ReadData2(rd2_c),
      .WriteRegister(wa_c), .WriteData(wd_c), .RegWrite(we_c),
      .Clear(clr_c), .Busy(busy_c)
   );

   // Reference model: plain arrays plus "sweep in progress / next index".
   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   logic [7:0]  m_c [8];
   bit          m_busy;
   int          m_idx;
   bit          c_busy;
   int          c_idx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_a(input logic [4:0] addr);
      if (addr == 0) return 32'd0;
      if (!m_busy && we && wa == addr) return wd;
      return m_a[addr];
   endfunction

   function automatic logic [31:0] exp_b(input logic [4:0] addr);
      return m_b[addr];
   endfunction

   function automatic logic [31:0] exp_c(input logic [2:0] addr);
      if (addr == 0) return 32'd0;
      if (!c_busy && we_c && wa_c == addr) return {24'd0, wd_c};
      return {24'd0, m_c[addr]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_a[i] = 0; m_b[i] = 0; end
      for (int i = 0; i < 8; i++) m_c[i] = 0;
      m_busy = 0; m_idx = 0; c_busy = 0; c_idx = 0;
   endtask

   // Apply the effect of one rising edge, using the inputs held across it.
   task automatic model_edge();
      if (m_busy) begin
         m_a[m_idx] = 0; m_b[m_idx] = 0;
         if (m_idx == 31) m_busy = 0; else m_idx++;
      end else if (clr) begin
         m_busy = 1; m_idx = 0;
      end else if (we) begin
         if (wa != 0) m_a[wa] = wd;
         m_b[wa] = wd;
      end
      if (c_busy) begin
         m_c[c_idx] = 0;
         if (c_idx == 7) c_busy = 0; else c_idx++;
      end else if (clr_c) begin
         c_busy = 1; c_idx = 0;
      end else if (we_c && wa_c != 0) begin
         m_c[wa_c] = wd_c;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic check_all(input string tag);
      check({tag, "_a1"}, rd1_a, exp_a(ra1));
      check({tag, "_a2"}, rd2_a, exp_a(ra2));
      check({tag, "_b1"}, rd1_b, exp_b(ra1));
      check({tag, "_b2"}, rd2_b, exp_b(ra2));
      check({tag, "_c1"}, {24'd0, rd1_c}, exp_c(ra1_c));
      check({tag, "_c2"}, {24'd0, rd2_c}, exp_c(ra2_c));
      check({tag, "_busy_a"}, {31'd0, busy_a}, {31'd0, m_busy});
      check({tag, "_busy_b"}, {31'd0, busy_b}, {31'd0, m_busy});
      check({tag, "_busy_c"}, {31'd0, busy_c}, {31'd0, c_busy});
   endtask

   task automatic idle_inputs();
      we = 0; clr = 0; we_c = 0; clr_c = 0;
   endtask

   task automatic write_ab(input logic [4:0] a, input logic [31:0] d);
      wa = a; wd = d; we = 1;
      step();
      we = 0;
   endtask

   int n;

   initial begin
      rst_n = 1; ra1 = 0; ra2 = 0; wa = 0; wd = 0;
      ra1_c = 0; ra2_c = 0; wa_c = 0; wd_c = 0;
      idle_inputs();
      model_reset();

      // Reset and sweep all addresses on both ports.
      #2 rst_n = 0;
      model_reset();
      #2;
      for (int i = 0; i < 32; i++) begin
         ra1 = i[4:0]; ra2 = 5'(31 - i); ra1_c = i[2:0]; ra2_c = 3'(7 - i);
         #1 check_all("reset");
      end
      @(negedge clk) rst_n = 1;

      // Write, overwrite, write-disable, decoder.
      ra1 = 2; ra2 = 2;
      write_ab(2, 42);   check_all("wr42");
      write_ab(2, 15);   check_all("wr15");
      wa = 2; wd = 150; we = 0;
      step();            check_all("we0");
      ra1 = 10;          #1 check_all("reg10");

      // Bypass before the edge; b shows old value until after the edge.
      ra1 = 5; ra2 = 6; wa = 5; wd = 32'hDEADBEEF; we = 1;
      #1 check_all("byp_pre");
      check("byp_a_lit", rd1_a, 32'hDEADBEEF);
      check("nobyp_b_lit", rd1_b, 32'd0);
      step();
      check_all("byp_post");
      check("nobyp_b_post", rd1_b, 32'hDEADBEEF);
      we = 0;

      // Zero register.
      ra1 = 0; ra2 = 0; wa = 0; wd = 1234; we = 1;
      #1 check_all("zero_pre");
      step();
      check_all("zero_post");
      check("zero_b_lit", rd1_b, 32'd1234);
      we = 0;

      // Port independence, then clear with a dropped write mid-sweep.
      write_ab(17, 1);
      write_ab(16, 1111);
      ra1 = 17; ra2 = 16;
      #1 check_all("indep");
      check("indep_lit", rd2_a, 32'd1111);
      clr = 1;
      step();
      clr = 0;
      n = 0;
      while (busy_a && n < 100) begin
         if (n == 4) begin wa = 3; wd = 7; we = 1; ra1 = 3; end
         else we = 0;
         #1 check_all("sweep");
         step();
         n++;
      end
      we = 0;
      check("busy_len32", n, 32);
      ra1 = 3; ra2 = 16; #1 check_all("post_clr");
      ra1 = 17; #1 check_all("post_clr17");
      check("post_clr3_lit", rd2_b, 32'd0);

      // Reset in the middle of a sweep.
      write_ab(31, 32'hA5A5A5A5);
      ra1 = 31; ra2 = 31; #1 check_all("pre31");
      clr = 1; step(); clr = 0;
      for (int i = 0; i < 10; i++) step();
      #2 rst_n = 0;
      model_reset();
      #1 check_all("rst_mid");
      check("rst_mid_busy_lit", {31'd0, busy_a}, 32'd0);
      @(negedge clk) rst_n = 1;
      ra1 = 4;
      write_ab(4, 9);
      check_all("after_rst");
      check("after_rst_lit", rd1_a, 32'd9);

      // Small instance: width/depth and sweep length.
      wa_c = 7; wd_c = 8'hFF; we_c = 1; step(); we_c = 0;
      ra1_c = 7; #1 check_all("c_ff");
      clr_c = 1; step(); clr_c = 0;
      n = 0;
      while (busy_c && n < 50) begin step(); n++; end
      check("busy_len8", n, 8);
      check_all("c_done");

      // Randomized traffic on all three instances.
      for (int it = 0; it < 400; it++) begin
         ra1 = 5'($urandom); ra2 = 5'($urandom); wa = 5'($urandom);
         wd = $urandom; we = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 7) == 0) ra2 = wa;
         ra1_c = 3'($urandom); ra2_c = 3'($urandom); wa_c = 3'($urandom);
         wd_c = 8'($urandom); we_c = ($urandom_range(0, 2) != 0);
         clr_c = ($urandom_range(0, 30) == 0);
         if ($urandom_range(0, 3) == 0) ra1_c = wa_c;
         #1 check_all("rnd_pre");
         step();
         check_all("rnd_post");
      end
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
